// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_pkg
// Description : Shared types and constants for the reorder buffer slice.
//               cdb_t is the result-broadcast / operand-lookup record, and
//               rob_entry_t is the per-entry state, exposed for trace reuse.
// Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

  localparam int ROB_WIDTH  = 3;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 1 << ROB_WIDTH;
  localparam int READ_PORTS = 2;

  typedef logic [ROB_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    rob_tag_t              tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [REG_WIDTH-1:0]  dest;
    logic [DATA_WIDTH-1:0] data;
  } rob_entry_t;

  // Tag increment; wraps DEPTH-1 -> 0 through the natural tag width.
  function automatic rob_tag_t tag_inc(rob_tag_t t);
    return t + rob_tag_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Dispatch / CDB / commit bundle of the reorder buffer.
//               slave  : reorder buffer side
//               master : dispatch / CDB / register-file side
//   flush, issue, issue_dest, cdb_valid/tag/data, read_tag  -> ROB
//   issue_ready, issue_tag, read, commit/_tag/_data/_reg    <- ROB
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
();

  logic                             flush;
  logic                             issue;
  logic [REG_WIDTH-1:0]             issue_dest;
  logic                             issue_ready;
  rob_tag_t                         issue_tag;
  logic                             cdb_valid;
  rob_tag_t                         cdb_tag;
  logic [DATA_WIDTH-1:0]            cdb_data;
  rob_tag_t [READ_PORTS-1:0]        read_tag;
  cdb_t     [READ_PORTS-1:0]        read;
  logic                             commit;
  rob_tag_t                         commit_tag;
  logic [DATA_WIDTH-1:0]            commit_data;
  logic [REG_WIDTH-1:0]             commit_reg;

  modport master (
    output flush, issue, issue_dest, cdb_valid, cdb_tag, cdb_data, read_tag,
    input  issue_ready, issue_tag, read, commit, commit_tag, commit_data, commit_reg
  );

  modport slave (
    input  flush, issue, issue_dest, cdb_valid, cdb_tag, cdb_data, read_tag,
    output issue_ready, issue_tag, read, commit, commit_tag, commit_data, commit_reg
  );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer_rob_ptr.sv
`default_nettype none
// ============================================================================
// Module      : rob_ptr
// Description : Head/tail/occupancy bookkeeping for the reorder buffer.
//   clk, reset      : clock, synchronous active-high reset
//   flush_i         : return to the empty state next cycle
//   issue_i         : issue request (accepted here when not full)
//   commit_i        : head entry retires this cycle
//   head_o, tail_o  : oldest entry / next entry to allocate
//   full_o, empty_o : derived from registered occupancy only
//   issue_accept_o  : issue request is taken this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr
  import reorder_buffer_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     flush_i,
  input  logic     issue_i,
  input  logic     commit_i,
  output rob_tag_t head_o,
  output rob_tag_t tail_o,
  output logic     full_o,
  output logic     empty_o,
  output logic     issue_accept_o
);

  localparam logic [ROB_WIDTH:0] c_full_count = (ROB_WIDTH+1)'(DEPTH);
  localparam logic [ROB_WIDTH:0] c_one        = (ROB_WIDTH+1)'(1);

  rob_tag_t           head_q, head_d;
  rob_tag_t           tail_q, tail_d;
  logic [ROB_WIDTH:0] count_q, count_d;
  logic               w_accept;

  assign full_o         = (count_q == c_full_count);
  assign empty_o        = (count_q == '0);
  // Refusal depends only on registered occupancy, never on a same-cycle commit.
  assign w_accept       = issue_i && !full_o && !flush_i;
  assign issue_accept_o = w_accept;
  assign head_o         = head_q;
  assign tail_o         = tail_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (commit_i) head_d = tag_inc(head_q);
      if (w_accept) tail_d = tag_inc(tail_q);
      case ({w_accept, commit_i})
        2'b10:   count_d = count_q + c_one;
        2'b01:   count_d = count_q - c_one;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement queue. Allocates rename tags on issue,
//               captures CDB results, commits in program order and forwards
//               completed-but-uncommitted results to dispatch.
//   clk, reset : clock, synchronous active-high reset
//   bus        : reorder_buffer_if.slave (issue, CDB, read ports, commit)
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  reorder_buffer_if.slave  bus
);

  rob_entry_t entries_q [DEPTH];

  rob_tag_t w_head;
  rob_tag_t w_tail;
  logic     w_full;
  logic     w_empty;
  logic     w_issue_accept;
  logic     w_commit;

  // Reset behaves like a flush, so it also suppresses retirement.
  assign w_commit = !w_empty && entries_q[w_head].busy && entries_q[w_head].done &&
                    !bus.flush && !reset;

  rob_ptr u_ptr (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (bus.flush),
    .issue_i        (bus.issue),
    .commit_i       (w_commit),
    .head_o         (w_head),
    .tail_o         (w_tail),
    .full_o         (w_full),
    .empty_o        (w_empty),
    .issue_accept_o (w_issue_accept)
  );

  // Order matters: the commit clear must win over a late CDB on the head,
  // and a fresh allocation must win over anything else on the tail entry.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i].busy <= 1'b0;
        entries_q[i].done <= 1'b0;
      end
    end else begin
      if (bus.cdb_valid && entries_q[bus.cdb_tag].busy) begin
        entries_q[bus.cdb_tag].done <= 1'b1;
        entries_q[bus.cdb_tag].data <= bus.cdb_data;
      end
      if (w_commit) begin
        entries_q[w_head].busy <= 1'b0;
        entries_q[w_head].done <= 1'b0;
      end
      if (w_issue_accept) begin
        entries_q[w_tail].busy <= 1'b1;
        entries_q[w_tail].done <= 1'b0;
        entries_q[w_tail].dest <= bus.issue_dest;
      end
    end
  end

  // Operand lookup: a same-cycle CDB broadcast bypasses the entry array.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      bus.read[p].tag = bus.read_tag[p];
      if (bus.cdb_valid && (bus.cdb_tag == bus.read_tag[p])) begin
        bus.read[p].valid = 1'b1;
        bus.read[p].data  = bus.cdb_data;
      end else begin
        bus.read[p].valid = entries_q[bus.read_tag[p]].busy && entries_q[bus.read_tag[p]].done;
        bus.read[p].data  = entries_q[bus.read_tag[p]].data;
      end
    end
  end

  assign bus.issue_ready = !w_full;
  assign bus.issue_tag   = w_tail;
  assign bus.commit      = w_commit;
  assign bus.commit_tag  = w_head;
  assign bus.commit_data = entries_q[w_head].data;
  assign bus.commit_reg  = entries_q[w_head].dest;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer (RW=3, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reorder_buffer_if bus();

  reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] tag;
    logic [4:0] dest;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] m_data [8];
  bit          m_done [8];
  logic [2:0]  m_tail;
  int          m_count;

  typedef struct {
    bit          rst;
    bit          iss;
    logic [4:0]  dest;
    bit          cv;
    logic [2:0]  ct;
    logic [31:0] cd;
    bit          e_commit;
    logic [2:0]  e_ctag;
    logic [2:0]  e_itag;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_sb(input logic [2:0] t);
    foreach (sb[k]) if (sb[k].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    sb.delete();
    for (int k = 0; k < 8; k++) m_done[k] = 1'b0;
    m_tail  = 3'd0;
    m_count = 0;
  endtask

  task automatic drive_idle();
    reset          = 1'b0;
    bus.flush      = 1'b0;
    bus.issue      = 1'b0;
    bus.issue_dest = '0;
    bus.cdb_valid  = 1'b0;
    bus.cdb_tag    = '0;
    bus.cdb_data   = '0;
    bus.read_tag[0] = '0;
    bus.read_tag[1] = '0;
  endtask

  // Checks every output against the model at the falling edge, advances the
  // model to match the coming rising edge, then returns idle inputs at +1.
  task automatic step();
    bit          exp_commit;
    bit          acc;
    bit          v;
    logic [31:0] d;
    logic [2:0]  rt;
    sb_t         e;
    @(negedge clk);
    if (reset) begin
      model_clear();
    end else begin
      exp_commit = (sb.size() > 0) && m_done[sb[0].tag] && !bus.flush;
      check("issue_ready", 32'(bus.issue_ready), 32'(m_count != 8));
      check("issue_tag", 32'(bus.issue_tag), 32'(m_tail));
      check("commit", 32'(bus.commit), 32'(exp_commit));
      if (exp_commit && bus.commit) begin
        check("commit_tag", 32'(bus.commit_tag), 32'(sb[0].tag));
        check("commit_reg", 32'(bus.commit_reg), 32'(sb[0].dest));
        check("commit_data", bus.commit_data, m_data[sb[0].tag]);
      end
      for (int p = 0; p < 2; p++) begin
        rt = bus.read_tag[p];
        if (bus.cdb_valid && bus.cdb_tag == rt) begin
          v = 1'b1;
          d = bus.cdb_data;
        end else begin
          v = in_sb(rt) && m_done[rt];
          d = m_data[rt];
        end
        check("read_valid", 32'(bus.read[p].valid), 32'(v));
        check("read_tag", 32'(bus.read[p].tag), 32'(rt));
        if (v) check("read_data", bus.read[p].data, d);
      end
      if (bus.flush) begin
        model_clear();
      end else begin
        acc = bus.issue && (m_count != 8);
        if (bus.cdb_valid && in_sb(bus.cdb_tag)) begin
          m_done[bus.cdb_tag] = 1'b1;
          m_data[bus.cdb_tag] = bus.cdb_data;
        end
        if (exp_commit) begin
          e = sb.pop_front();
          m_done[e.tag] = 1'b0;
          m_count--;
        end
        if (acc) begin
          sb.push_back('{m_tail, bus.issue_dest});
          m_done[m_tail] = 1'b0;
          m_tail++;
          m_count++;
        end
      end
    end
    @(posedge clk);
    #1;
    drive_idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
  endtask

  task automatic do_issue(input logic [4:0] dest);
    bus.issue      = 1'b1;
    bus.issue_dest = dest;
    step();
  endtask

  task automatic do_cdb(input logic [2:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    drive_idle();
    for (int k = 0; k < 8; k++) m_data[k] = '0;

    //            rst iss dest cv ct  cd     commit ctag itag
    vt[0]  = '{0, 1, 5'd5, 0, 3'd0, 32'h00, 0, 3'd0, 3'd0};
    vt[1]  = '{0, 0, 5'd0, 1, 3'd0, 32'hAA, 0, 3'd0, 3'd1};
    vt[2]  = '{0, 0, 5'd0, 0, 3'd0, 32'h00, 1, 3'd0, 3'd1};
    vt[3]  = '{1, 0, 5'd0, 0, 3'd0, 32'h00, 0, 3'd0, 3'd0};
    vt[4]  = '{0, 1, 5'd1, 0, 3'd0, 32'h00, 0, 3'd0, 3'd0};
    vt[5]  = '{0, 1, 5'd2, 0, 3'd0, 32'h00, 0, 3'd0, 3'd1};
    vt[6]  = '{0, 1, 5'd3, 0, 3'd0, 32'h00, 0, 3'd0, 3'd2};
    vt[7]  = '{0, 0, 5'd0, 1, 3'd2, 32'h02, 0, 3'd0, 3'd3};
    vt[8]  = '{0, 0, 5'd0, 1, 3'd1, 32'h01, 0, 3'd0, 3'd3};
    vt[9]  = '{0, 0, 5'd0, 1, 3'd0, 32'h00, 0, 3'd0, 3'd3};
    vt[10] = '{0, 0, 5'd0, 0, 3'd0, 32'h00, 1, 3'd0, 3'd3};
    vt[11] = '{0, 0, 5'd0, 0, 3'd0, 32'h00, 1, 3'd1, 3'd3};
    vt[12] = '{0, 0, 5'd0, 0, 3'd0, 32'h00, 1, 3'd2, 3'd3};
    vt[13] = '{0, 0, 5'd0, 0, 3'd0, 32'h00, 0, 3'd0, 3'd3};

    do_reset();
    check("reset_ready", 32'(bus.issue_ready), 32'd1);
    check("reset_tag", 32'(bus.issue_tag), 32'd0);
    check("reset_commit", 32'(bus.commit), 32'd0);
    check("reset_read_valid", 32'(bus.read[0].valid), 32'd0);

    // Basic issue/complete/commit and out-of-order completion.
    for (int i = 0; i < 14; i++) begin
      reset          = vt[i].rst;
      bus.issue      = vt[i].iss;
      bus.issue_dest = vt[i].dest;
      bus.cdb_valid  = vt[i].cv;
      bus.cdb_tag    = vt[i].ct;
      bus.cdb_data   = vt[i].cd;
      #2;
      if (!vt[i].rst) begin
        check("tbl_commit", 32'(bus.commit), 32'(vt[i].e_commit));
        check("tbl_issue_tag", 32'(bus.issue_tag), 32'(vt[i].e_itag));
        if (vt[i].e_commit) check("tbl_commit_tag", 32'(bus.commit_tag), 32'(vt[i].e_ctag));
      end
      step();
    end

    // Fill, refusal when full (even with a same-cycle commit), then wrap.
    do_reset();
    for (int i = 0; i < 8; i++) do_issue(5'(i + 8));
    check("fill_ready", 32'(bus.issue_ready), 32'd0);
    bus.issue = 1'b1; bus.issue_dest = 5'd20;
    #2 check("refused_ready", 32'(bus.issue_ready), 32'd0);
    step();
    check("refused_tail", 32'(bus.issue_tag), 32'd0);
    do_cdb(3'd0, 32'h100);
    bus.issue = 1'b1; bus.issue_dest = 5'd21;
    #2;
    check("full_commit", 32'(bus.commit), 32'd1);
    check("full_commit_ready", 32'(bus.issue_ready), 32'd0);
    step();
    bus.issue = 1'b1; bus.issue_dest = 5'd22;
    #2;
    check("wrap_ready", 32'(bus.issue_ready), 32'd1);
    check("wrap_tag", 32'(bus.issue_tag), 32'd0);
    step();
    check("wrap_tail_after", 32'(bus.issue_tag), 32'd1);

    // Forwarding from the array and bypass from the CDB.
    do_reset();
    for (int i = 0; i < 5; i++) do_issue(5'(i + 1));
    do_cdb(3'd3, 32'h33);
    bus.read_tag[0] = 3'd3;
    bus.read_tag[1] = 3'd4;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd4; bus.cdb_data = 32'h44;
    #2;
    check("fwd0_valid", 32'(bus.read[0].valid), 32'd1);
    check("fwd0_data", bus.read[0].data, 32'h33);
    check("byp1_valid", 32'(bus.read[1].valid), 32'd1);
    check("byp1_tag", 32'(bus.read[1].tag), 32'd4);
    check("byp1_data", bus.read[1].data, 32'h44);
    check("fwd_no_commit", 32'(bus.commit), 32'd0);
    step();

    // Flush with a done head and simultaneous issue + CDB.
    do_cdb(3'd0, 32'h10);
    bus.flush = 1'b1;
    bus.issue = 1'b1; bus.issue_dest = 5'd9;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3'd1; bus.cdb_data = 32'h11;
    #2 check("flush_commit", 32'(bus.commit), 32'd0);
    step();
    check("flush_tag", 32'(bus.issue_tag), 32'd0);
    check("flush_ready", 32'(bus.issue_ready), 32'd1);
    check("flush_commit_after", 32'(bus.commit), 32'd0);

    // Stale CDB after flush must not mark a later allocation done.
    do_cdb(3'd6, 32'h66);
    for (int i = 0; i < 7; i++) do_issue(5'(i + 24));
    step();
    step();
    bus.read_tag[0] = 3'd6;
    #2;
    check("stale_read_valid", 32'(bus.read[0].valid), 32'd0);
    check("stale_no_commit", 32'(bus.commit), 32'd0);
    step();

    // Drain through the scoreboard, completing youngest first.
    for (int i = 6; i >= 0; i--) do_cdb(3'(i), 32'h600 + 32'(i));
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries never retired", sb.size());
    end
    check("drain_commit", 32'(bus.commit), 32'd0);
    check("drain_tag", 32'(bus.issue_tag), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
